reg_operand_fetch: RTL

Read-side counterpart of the register-bank write-address selector in the multicycle MIPS datapath. On a start pulse from the control unit, it resolves two source-register addresses from the same 3-bit select encoding the write side uses. It drives the bank's two read ports, captures the returned data into the A and B operand registers, and signals completion. Writes to the bank that are in flight during the fetch are snooped and forwarded, so A and B never hold stale data.

---
 rtl/mips_regsel_pkg.sv | 22 ++
 rtl/reg_addr_sel.sv | 27 ++
 rtl/reg_operand_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_regsel_pkg.sv
// Register-select encodings and constants shared by the read- and write-side
// register address selectors of the multicycle MIPS datapath.
package mips_regsel_pkg;

  localparam logic [2:0] SEL_RT = 3'd0;
  localparam logic [2:0] SEL_RD = 3'd1;
  localparam logic [2:0] SEL_RS = 3'd2;
  localparam logic [2:0] SEL_SP = 3'd3;
  localparam logic [2:0] SEL_RA = 3'd4;

  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/reg_addr_sel.sv
// Combinational map from a 3-bit register select plus instruction fields to a
// bank address; reserved codes resolve to r0 and raise err.
module reg_addr_sel
  import mips_regsel_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] addr,
  output logic       err
);

  always_comb begin
    addr = REG_ZERO;
    err  = 1'b0;
    case (sel)
      SEL_RT:  addr = rt;
      SEL_RD:  addr = rd;
      SEL_RS:  addr = rs;
      SEL_SP:  addr = REG_SP;
      SEL_RA:  addr = REG_RA;
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// Multicycle operand fetch: resolves two source registers, reads the bank,
// forwards in-flight writes and captures the results into A and B.
module reg_operand_fetch
  import mips_regsel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  SelA,
  input  logic [2:0]  SelB,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [4:0]  ReadReg1,
  output logic [4:0]  ReadReg2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        sel_err
);

  fetch_state_e state_reg, state_next;

  logic [4:0]  addr_a_sel, addr_b_sel;
  logic        err_a, err_b;
  logic [4:0]  addr_a_reg, addr_b_reg;
  logic [31:0] hold_a_reg, hold_b_reg;
  logic        pend_a_reg, pend_b_reg;
  logic [31:0] a_reg, b_reg, a_next, b_next;
  logic        sel_err_reg;
  logic        fwd_a, fwd_b;

  reg_addr_sel u_sel_a (.sel(SelA), .rs(rs), .rt(rt), .rd(rd), .addr(addr_a_sel), .err(err_a));
  reg_addr_sel u_sel_b (.sel(SelB), .rs(rs), .rt(rt), .rd(rd), .addr(addr_b_sel), .err(err_b));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_ADDR;
      end
      ST_ADDR: state_next = ST_CAPT;
      ST_CAPT: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Writes to r0 are never forwarded; the bank discards them anyway.
  assign fwd_a = RegWrite && (WriteReg == addr_a_reg) && (addr_a_reg != REG_ZERO);
  assign fwd_b = RegWrite && (WriteReg == addr_b_reg) && (addr_b_reg != REG_ZERO);

  // Capture priority: same-cycle write, then write held from ADDR, then bank.
  always_comb begin
    if (addr_a_reg == REG_ZERO) a_next = 32'd0;
    else if (fwd_a)             a_next = WriteData;
    else if (pend_a_reg)        a_next = hold_a_reg;
    else                        a_next = ReadData1;

    if (addr_b_reg == REG_ZERO) b_next = 32'd0;
    else if (fwd_b)             b_next = WriteData;
    else if (pend_b_reg)        b_next = hold_b_reg;
    else                        b_next = ReadData2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a_reg  <= REG_ZERO;
      addr_b_reg  <= REG_ZERO;
      hold_a_reg  <= 32'd0;
      hold_b_reg  <= 32'd0;
      pend_a_reg  <= 1'b0;
      pend_b_reg  <= 1'b0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      sel_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_a_reg  <= addr_a_sel;
            addr_b_reg  <= addr_b_sel;
            sel_err_reg <= err_a | err_b;
          end
        end
        ST_ADDR: begin
          // The bank samples its read address at the same edge this write
          // commits, so the read data coming back in CAPT will be stale.
          if (fwd_a) begin
            hold_a_reg <= WriteData;
            pend_a_reg <= 1'b1;
          end
          if (fwd_b) begin
            hold_b_reg <= WriteData;
            pend_b_reg <= 1'b1;
          end
        end
        ST_CAPT: begin
          a_reg <= a_next;
          b_reg <= b_next;
        end
        ST_DONE: begin
          pend_a_reg <= 1'b0;
          pend_b_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ReadReg1 = addr_a_reg;
  assign ReadReg2 = addr_b_reg;
  assign A        = a_reg;
  assign B        = b_reg;
  assign sel_err  = sel_err_reg;

endmodule
